posted_recv_queue: RTL and testbench

//  Posted-receive queue (PRQ): holds receive requests posted by the host/Nios before their message arrives, in post order.

---
 rtl/posted_recv_queue.sv | 258 +++++++++++++++++++++++++
 tb/tb_posted_recv_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/posted_recv_queue.sv
// Posted-receive queue: linked list of posted requests searched oldest-first
// with MPI wildcard matching; unlinked entries return to a free list.
module posted_recv_queue #(
  parameter int packetizer_width = 128,
  parameter int ADDR_WIDTH       = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 request,
  input  logic                        post,
  input  logic [packetizer_width-1:0] message,
  input  logic                        find,
  output logic                        busy,
  output logic                        found,
  output logic                        not_found,
  output logic [31:0]                 matched_request,
  output logic                        post_drop,
  output logic                        Q_full,
  output logic                        Q_empty
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] NULL = '0;
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_INS_A, ST_INS_B, ST_INS_C,
    ST_S_RD, ST_S_CHK, ST_S_UNLINK, ST_S_FREE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_WIDTH-1:0] free_head_q, free_head_d, count_q, count_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, prev_q, prev_d, nxt_q, nxt_d;
  logic [ADDR_WIDTH-1:0] alloc_q, alloc_d, init_idx_q, init_idx_d;
  logic                  pend_find_q, pend_find_d;
  logic [23:0]           msg_q, msg_d;
  logic [31:0]           req_q, req_d, hit_key_q, hit_key_d;
  logic                  found_q, found_d, not_found_q, not_found_d;
  logic                  drop_q, drop_d;
  logic [31:0]           matched_q, matched_d;

  logic [31:0]           key_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] next_mem [DEPTH];
  logic [31:0]           key_rd_q;
  logic [ADDR_WIDTH-1:0] next_rd_q;
  logic                  key_we, next_we;
  logic [ADDR_WIDTH-1:0] next_waddr, next_wdata, rd_addr;
  logic                  start_search, match;

  logic unused_msg_bits;
  assign unused_msg_bits = ^{message[packetizer_width-1:112], message[87:0]};

  always_ff @(posedge clk) begin
    if (key_we) key_mem[free_head_q] <= req_q;
    if (next_we) next_mem[next_waddr] <= next_wdata;
    key_rd_q  <= key_mem[rd_addr];
    next_rd_q <= next_mem[rd_addr];
  end

  // Messages never carry wildcards; only the stored request side may.
  assign match = (key_rd_q[23:16] == msg_q[23:16]) &&
                 ((key_rd_q[15:8] == 8'hFF) || (key_rd_q[15:8] == msg_q[15:8])) &&
                 ((key_rd_q[7:0]  == 8'hFF) || (key_rd_q[7:0]  == msg_q[7:0]));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      head_q      <= NULL;
      tail_q      <= NULL;
      free_head_q <= ONE;
      count_q     <= NULL;
      ptr_q       <= NULL;
      prev_q      <= NULL;
      nxt_q       <= NULL;
      alloc_q     <= NULL;
      init_idx_q  <= ONE;
      pend_find_q <= 1'b0;
      msg_q       <= '0;
      req_q       <= '0;
      hit_key_q   <= '0;
      found_q     <= 1'b0;
      not_found_q <= 1'b0;
      drop_q      <= 1'b0;
      matched_q   <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      free_head_q <= free_head_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      prev_q      <= prev_d;
      nxt_q       <= nxt_d;
      alloc_q     <= alloc_d;
      init_idx_q  <= init_idx_d;
      pend_find_q <= pend_find_d;
      msg_q       <= msg_d;
      req_q       <= req_d;
      hit_key_q   <= hit_key_d;
      found_q     <= found_d;
      not_found_q <= not_found_d;
      drop_q      <= drop_d;
      matched_q   <= matched_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    free_head_d  = free_head_q;
    count_d      = count_q;
    ptr_d        = ptr_q;
    prev_d       = prev_q;
    nxt_d        = nxt_q;
    alloc_d      = alloc_q;
    init_idx_d   = init_idx_q;
    pend_find_d  = pend_find_q;
    msg_d        = msg_q;
    req_d        = req_q;
    hit_key_d    = hit_key_q;
    found_d      = 1'b0;
    not_found_d  = 1'b0;
    drop_d       = 1'b0;
    matched_d    = '0;
    key_we       = 1'b0;
    next_we      = 1'b0;
    next_waddr   = ptr_q;
    next_wdata   = NULL;
    rd_addr      = ptr_q;
    start_search = 1'b0;

    case (state_q)
      ST_INIT: begin
        next_we    = 1'b1;
        next_waddr = init_idx_q;
        next_wdata = (init_idx_q == MAX) ? NULL : init_idx_q + ONE;
        if (init_idx_q == MAX) begin
          free_head_d = ONE;
          state_d     = ST_IDLE;
        end else begin
          init_idx_d = init_idx_q + ONE;
        end
      end
      ST_IDLE: begin
        if (post) begin
          if (count_q == MAX) begin
            drop_d = 1'b1;
            if (find) begin
              msg_d        = message[111:88];
              start_search = 1'b1;
            end
          end else begin
            req_d   = request;
            state_d = ST_INS_A;
            if (find) begin
              pend_find_d = 1'b1;
              msg_d       = message[111:88];
            end
          end
        end else if (find) begin
          msg_d        = message[111:88];
          start_search = 1'b1;
        end
      end
      ST_INS_A: begin
        key_we  = 1'b1;
        alloc_d = free_head_q;
        rd_addr = free_head_q;
        state_d = ST_INS_B;
      end
      ST_INS_B: begin
        free_head_d = next_rd_q;
        next_we     = 1'b1;
        next_waddr  = alloc_q;
        next_wdata  = NULL;
        state_d     = ST_INS_C;
      end
      ST_INS_C: begin
        if (count_q == NULL) begin
          head_d = alloc_q;
        end else begin
          next_we    = 1'b1;
          next_waddr = tail_q;
          next_wdata = alloc_q;
        end
        tail_d  = alloc_q;
        count_d = count_q + ONE;
        state_d = ST_IDLE;
        // A find that arrived alongside the post starts straight away.
        if (pend_find_q) start_search = 1'b1;
      end
      ST_S_RD: begin
        rd_addr = ptr_q;
        state_d = ST_S_CHK;
      end
      ST_S_CHK: begin
        nxt_d     = next_rd_q;
        hit_key_d = key_rd_q;
        if (match) begin
          state_d = ST_S_UNLINK;
        end else if (next_rd_q != NULL) begin
          prev_d  = ptr_q;
          ptr_d   = next_rd_q;
          state_d = ST_S_RD;
        end else begin
          not_found_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_S_UNLINK: begin
        if (prev_q == NULL) begin
          head_d = nxt_q;
        end else begin
          next_we    = 1'b1;
          next_waddr = prev_q;
          next_wdata = nxt_q;
        end
        if (ptr_q == tail_q) tail_d = prev_q;
        found_d   = 1'b1;
        matched_d = hit_key_q;
        state_d   = ST_S_FREE;
      end
      ST_S_FREE: begin
        next_we     = 1'b1;
        next_waddr  = ptr_q;
        next_wdata  = free_head_q;
        free_head_d = ptr_q;
        count_d     = count_q - ONE;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_search) begin
      pend_find_d = 1'b0;
      if (count_d == NULL) begin
        not_found_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        ptr_d   = head_d;
        prev_d  = NULL;
        state_d = ST_S_RD;
      end
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign found           = found_q;
  assign not_found       = not_found_q;
  assign matched_request = matched_q;
  assign post_drop       = drop_q;
  assign Q_full          = (count_q == MAX);
  assign Q_empty         = (count_q == NULL);

endmodule

// File: tb/tb_posted_recv_queue.sv
// Bench for posted_recv_queue (ADDR_WIDTH=3): a list model predicts each
// search result and its latency; results are popped from a scoreboard.
module tb_posted_recv_queue;

  localparam int MAXE = 7;

  logic         clk, rst, post, find;
  logic [31:0]  request;
  logic [127:0] message;
  logic         busy, found, not_found, post_drop, Q_full, Q_empty;
  logic [31:0]  matched_request;

  posted_recv_queue #(.packetizer_width(128), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .request(request), .post(post), .message(message),
    .find(find), .busy(busy), .found(found), .not_found(not_found),
    .matched_request(matched_request), .post_drop(post_drop),
    .Q_full(Q_full), .Q_empty(Q_empty)
  );

  typedef struct {
    logic        hit;
    logic [31:0] req;
    int          lat;
    int          t;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  exp_t        mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit req_match(logic [31:0] r, logic [7:0] c, logic [7:0] s, logic [7:0] t);
    return (r[23:16] == c) && (r[15:8] == 8'hFF || r[15:8] == s) &&
           (r[7:0] == 8'hFF || r[7:0] == t);
  endfunction

  always @(negedge clk) begin
    if (found === 1'b1 || not_found === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("found", {31'd0, found}, {31'd0, mon_e.hit});
        chk("not_found", {31'd0, not_found}, {31'd0, !mon_e.hit});
        chk("matched_request", matched_request, mon_e.req);
        chk("latency", cyc - mon_e.t, mon_e.lat);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", n, 0);
    @(negedge clk);
    chk("q_empty", {31'd0, Q_empty}, {31'd0, model.size() == 0});
    chk("q_full", {31'd0, Q_full}, {31'd0, model.size() == MAXE});
  endtask

  task automatic do_reset_init();
    int n = 0;
    rst = 1'b1;
    post = 1'b0;
    find = 1'b0;
    model.delete();
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_not_found", {31'd0, not_found}, 32'd0);
    chk("rst_post_drop", {31'd0, post_drop}, 32'd0);
    chk("rst_matched", matched_request, 32'd0);
    chk("rst_q_full", {31'd0, Q_full}, 32'd0);
    rst = 1'b0;
    while (busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("init_cycles", n, MAXE);
    chk("init_q_empty", {31'd0, Q_empty}, 32'd1);
    chk("init_q_full", {31'd0, Q_full}, 32'd0);
  endtask

  task automatic do_post(input logic [31:0] req);
    bit exp_drop;
    exp_drop = (model.size() == MAXE);
    if (!exp_drop) model.push_back(req);
    request = req;
    post = 1'b1;
    @(negedge clk);
    post = 1'b0;
    chk("post_drop", {31'd0, post_drop}, {31'd0, exp_drop});
    wait_idle();
  endtask

  task automatic do_find(input logic [7:0] c, input logic [7:0] s, input logic [7:0] t,
                         input bit with_post, input logic [31:0] req);
    exp_t e;
    int   k = -1;
    int   extra = 0;
    if (with_post) begin
      model.push_back(req);
      extra = 3;
    end
    foreach (model[i]) if (k < 0 && req_match(model[i], c, s, t)) k = i;
    e.t = cyc;
    if (k >= 0) begin
      e.hit = 1'b1;
      e.req = model[k];
      e.lat = 2 * k + 4 + extra;
      model.delete(k);
    end else begin
      e.hit = 1'b0;
      e.req = 32'd0;
      e.lat = 2 * model.size() + 1 + extra;
    end
    sb.push_back(e);
    message = {16'h0, c, s, t, 88'h0};
    request = req;
    post = with_post;
    find = 1'b1;
    @(negedge clk);
    find = 1'b0;
    post = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    post = 1'b0;
    find = 1'b0;
    request = '0;
    message = '0;
    @(negedge clk);
    do_reset_init();
    do_find(8'd1, 8'd2, 8'd4, 1'b0, 32'd0);

    do_post(32'h00010203);
    do_post(32'h00010204);
    do_find(8'd9, 8'd2, 8'd4, 1'b0, 32'd0);
    do_find(8'd1, 8'd2, 8'd4, 1'b0, 32'd0);
    do_find(8'd1, 8'd2, 8'd3, 1'b0, 32'd0);

    do_post(32'h000102FF);
    do_post(32'h00010205);
    do_find(8'd1, 8'd2, 8'd5, 1'b0, 32'd0);
    do_find(8'd1, 8'd3, 8'd5, 1'b0, 32'd0);
    do_find(8'd1, 8'd2, 8'd5, 1'b0, 32'd0);

    for (int i = 0; i < MAXE; i++) do_post(32'h00030100 + i);
    do_post(32'h00030107);
    do_find(8'd3, 8'd1, 8'd6, 1'b0, 32'd0);
    do_post(32'h00030107);
    for (int i = 0; i < 6; i++) do_find(8'd3, 8'd1, 8'(i), 1'b0, 32'd0);
    do_find(8'd3, 8'd1, 8'd7, 1'b0, 32'd0);

    do_find(8'd4, 8'd5, 8'd6, 1'b1, 32'h00040506);

    do_post(32'h00050101);
    do_post(32'h00050102);
    do_post(32'h00050103);
    message = {16'h0, 8'd9, 8'd9, 8'd9, 88'h0};
    find = 1'b1;
    @(negedge clk);
    find = 1'b0;
    repeat (2) @(negedge clk);
    do_reset_init();
    do_find(8'd5, 8'd1, 8'd1, 1'b0, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
